// File: rtl/step_clock_ctrl_if.sv
// Signal bundle between the board button/switch logic and the step-clock controller.
// The controller attaches through the slave modport. The board side or a bench attaches through master.
interface step_clock_ctrl_if #(
  parameter int DIV_WIDTH   = 24,
  parameter int BURST_WIDTH = 8,
  parameter int CNT_WIDTH   = 16
);
  logic [1:0]             mode;
  logic [DIV_WIDTH-1:0]   div_value;
  logic [BURST_WIDTH-1:0] burst_len;
  logic                   btn_raw;
  logic                   step_en;
  logic                   busy;
  logic                   btn_level;
  logic [CNT_WIDTH-1:0]   step_count;

  modport master (
    output mode, div_value, burst_len, btn_raw,
    input  step_en, busy, btn_level, step_count
  );

  modport slave (
    input  mode, div_value, burst_len, btn_raw,
    output step_en, busy, btn_level, step_count
  );
endinterface

// File: rtl/step_clock_ctrl.sv
// Step-enable generator for the state-machine datapath. It supports hold, debounced single-step, divided free-run
// and N-step burst modes. Everything runs in the single clk domain, and the only output that gates other logic is step_en.
module step_clock_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DIV_WIDTH       = 24,
  parameter int BURST_WIDTH     = 8,
  parameter int CNT_WIDTH       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  step_clock_ctrl_if.slave bus
);

  localparam int DB_WIDTH = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [BURST_WIDTH-1:0] BURST_ONE = {{(BURST_WIDTH-1){1'b0}}, 1'b1};

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_SINGLE = 2'b01;
  localparam logic [1:0] MODE_FREE   = 2'b10;
  localparam logic [1:0] MODE_BURST  = 2'b11;

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DB_WIDTH-1:0]    r_db_cnt;
  logic                   r_btn_level;
  logic                   r_level_q;
  logic [1:0]             r_mode_q;
  logic [DIV_WIDTH-1:0]   r_div_cnt;
  logic [BURST_WIDTH-1:0] r_remaining;
  state_t                 r_state;
  logic                   r_step_en;
  logic                   r_busy;
  logic [CNT_WIDTH-1:0]   r_step_count;

  logic                   w_btn_s;
  logic                   w_press;
  logic [DIV_WIDTH-1:0]   w_div_eff;
  logic                   w_tick;
  state_t                 w_state_next;
  logic [DIV_WIDTH-1:0]   w_div_next;
  logic [BURST_WIDTH-1:0] w_rem_next;
  logic                   w_step_next;
  logic                   w_busy_next;

  assign w_btn_s = r_sync[SYNC_STAGES-1];
  assign w_press = r_btn_level & ~r_level_q;

  // The debounced level only moves after DEBOUNCE_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync      <= '0;
      r_db_cnt    <= '0;
      r_btn_level <= 1'b0;
      r_level_q   <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], bus.btn_raw};
      r_level_q <= r_btn_level;
      if (w_btn_s == r_btn_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_btn_level <= w_btn_s;
        r_db_cnt    <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  // A mode change behaves as if the divider had already been cleared, so the first period is a full one.
  assign w_div_eff = (bus.mode != r_mode_q) ? '0 : r_div_cnt;
  assign w_tick    = (w_div_eff >= bus.div_value);

  always_comb begin
    w_state_next = r_state;
    w_div_next   = '0;
    w_rem_next   = r_remaining;
    w_step_next  = 1'b0;
    w_busy_next  = 1'b0;
    unique case (bus.mode)
      MODE_SINGLE: begin
        w_step_next = w_press;
      end
      MODE_FREE: begin
        w_step_next = w_tick;
        w_div_next  = w_tick ? '0 : w_div_eff + 1'b1;
      end
      MODE_BURST: begin
        if (r_state == S_IDLE) begin
          // The press itself counts as the first step, so the burst starts on the very next cycle.
          if (w_press && (bus.burst_len != '0)) begin
            w_step_next = 1'b1;
            w_busy_next = 1'b1;
            w_rem_next  = bus.burst_len - 1'b1;
            if (bus.burst_len != BURST_ONE) begin
              w_state_next = S_BURST;
            end
          end
        end else begin
          w_busy_next = 1'b1;
          if (w_tick) begin
            w_step_next = 1'b1;
            w_rem_next  = r_remaining - 1'b1;
            if (r_remaining == BURST_ONE) begin
              w_state_next = S_IDLE;
            end
          end else begin
            w_div_next = w_div_eff + 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
    if (bus.mode != MODE_BURST) begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_mode_q     <= MODE_HOLD;
      r_div_cnt    <= '0;
      r_remaining  <= '0;
      r_step_en    <= 1'b0;
      r_busy       <= 1'b0;
      r_step_count <= '0;
    end else begin
      r_state      <= w_state_next;
      r_mode_q     <= bus.mode;
      r_div_cnt    <= w_div_next;
      r_remaining  <= w_rem_next;
      r_step_en    <= w_step_next;
      r_busy       <= w_busy_next;
      r_step_count <= r_step_count + CNT_WIDTH'(w_step_next);
    end
  end

  assign bus.step_en    = r_step_en;
  assign bus.busy       = r_busy;
  assign bus.btn_level  = r_btn_level;
  assign bus.step_count = r_step_count;

endmodule
